timer_entry_loader: RTL and testbench

- Keypad-side writer for the microwave countdown chain: collects BCD digits as MM:SS and validates them.
- Issues a one-cycle parallel load into the down-counter chain, then gates its count enable.
- Watches the chain's all-zero terminal count to detect end of cook.
- Sits between the keypad decoder and the cascaded mod-10/mod-6 digit counters.

---
 rtl/microwave_pkg.sv | 14 +
 rtl/bcd_entry_shift.sv | 32 +++
 rtl/timer_entry_loader.sv | 126 ++++++++++++
 tb/tb_timer_entry_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encoding and constants for the microwave timer entry path
package microwave_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        PAUSED = 3'd4,
        DONE   = 3'd5
    } state_t;
    localparam int BCD_W = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam logic [15:0] QUICK_TIME = 16'h0030;
endpackage

// File: rtl/bcd_entry_shift.sv
// bcd_entry_shift: nibble shift register with digit counter; stops accepting once full
module bcd_entry_shift
    import microwave_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int W = BCD_W * DIGITS,
    parameter int CW = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             clear,
    input  logic [BCD_W-1:0] digit,
    output logic [W-1:0]     entry,
    output logic [CW-1:0]    count,
    output logic             full
);
    assign full = count == CW'(DIGITS);
    // clear together with shift starts a fresh entry holding just that digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= '0;
            count <= '0;
        end else if (clear) begin
            entry <= shift ? W'(digit) : '0;
            count <= shift ? CW'(1) : '0;
        end else if (shift && !full) begin
            entry <= {entry[W-BCD_W-1:0], digit};
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/timer_entry_loader.sv
// timer_entry_loader: keypad MM:SS entry, validation and load/enable control of the countdown chain.
// Define QUICK_START_EN to make a start with no digits load 00:30.
module timer_entry_loader #(
    parameter int DIGITS = 4,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_digit,
    input  logic                start,
    input  logic                pause,
    input  logic                clear,
    input  logic                timer_zero,
    output logic                load,
    output logic [4*DIGITS-1:0] load_data,
    output logic                count_en,
    output logic [4*DIGITS-1:0] entry_digits,
    output logic                done,
    output logic                err,
    output logic [2:0]          state
);
    import microwave_pkg::*;
    localparam int W = BCD_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    state_t st, nxt;
    logic [CW-1:0] count;
    logic full, key_bcd, legal, shift, clr_e, ld_go, ld_quick, err_set;
    bcd_entry_shift #(.DIGITS(DIGITS)) u_shift (
        .clk   (clk),
        .reset (reset),
        .shift (shift),
        .clear (clr_e),
        .digit (key_digit),
        .entry (entry_digits),
        .count (count),
        .full  (full)
    );
    assign key_bcd = key_valid && key_digit <= 4'd9;
    assign legal = count != '0 && entry_digits[7:4] <= BCD_W'(SEC_TENS_MAX) && entry_digits != '0;
    always_comb begin
        nxt = st;
        shift = 1'b0;
        clr_e = 1'b0;
        ld_go = 1'b0;
        ld_quick = 1'b0;
        err_set = 1'b0;
        if (clear) begin
            nxt = IDLE;
            clr_e = 1'b1;
        end else begin
            case (st)
                IDLE: begin
`ifdef QUICK_START_EN
                    if (start) begin
                        nxt = LOAD;
                        ld_go = 1'b1;
                        ld_quick = 1'b1;
                    end else if (key_bcd) begin
                        nxt = ENTRY;
                        shift = 1'b1;
                    end
`else
                    if (key_bcd) begin
                        nxt = ENTRY;
                        shift = 1'b1;
                    end
`endif
                end
                ENTRY: begin
                    // start takes precedence; a key arriving alongside it is dropped
                    if (start) begin
`ifdef QUICK_START_EN
                        if (count == '0) begin
                            nxt = LOAD;
                            ld_go = 1'b1;
                            ld_quick = 1'b1;
                        end else if (legal) begin
                            nxt = LOAD;
                            ld_go = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
`else
                        if (legal) begin
                            nxt = LOAD;
                            ld_go = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
`endif
                    end else begin
                        shift = key_bcd;
                    end
                end
                LOAD: nxt = RUN;
                RUN: nxt = pause ? PAUSED : timer_zero ? DONE : RUN;
                PAUSED: nxt = (start && !pause) ? RUN : PAUSED;
                DONE: begin
                    if (key_bcd) begin
                        nxt = ENTRY;
                        clr_e = 1'b1;
                        shift = 1'b1;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= IDLE;
            load_data <= '0;
            err <= 1'b0;
        end else begin
            st <= nxt;
            err <= err_set;
            if (ld_go) load_data <= ld_quick ? W'(QUICK_TIME) : entry_digits;
        end
    end
    // decoded from state so an asynchronous reset drops them immediately
    assign load = st == LOAD;
    assign count_en = st == RUN;
    assign done = st == DONE;
    assign state = st;
endmodule

// File: tb/tb_timer_entry_loader.sv
// tb_timer_entry_loader: scoreboard bench; expected load words queued at start, checked on each load pulse
module tb_timer_entry_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_valid = 1'b0;
    logic [3:0] key_digit = '0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic clear = 1'b0;
    logic timer_zero = 1'b0;
    logic load, count_en, done, err;
    logic [15:0] load_data, entry_digits;
    logic [2:0] state;
    int tests = 0;
    int fails = 0;
    logic [15:0] sb[$];

    timer_entry_loader dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .pause(pause), .clear(clear), .timer_zero(timer_zero),
        .load(load), .load_data(load_data), .count_en(count_en),
        .entry_digits(entry_digits), .done(done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && load) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL load_unexpected: load=1 load_data=%h, no load expected", load_data);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                if (load_data !== exp) begin
                    fails++;
                    $display("FAIL load_data: got %h expected %h", load_data, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_outs", {11'd0, load, count_en, done, err, 1'b0}, 16'd0);
        chk("rst_entry", entry_digits, 16'h0000);
        chk("rst_load_data", load_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_run_done();
        key(4'd1); key(4'd2); key(4'd3); key(4'd0);
        chk("entry_1230", entry_digits, 16'h1230);
        chk("entry_state", 16'(state), 16'd1);
        sb.push_back(16'h1230);
        pulse_start();
        chk("load_state", 16'(state), 16'd2);
        chk("load_pulse", {15'd0, load}, 16'd1);
        chk("en_in_load", {15'd0, count_en}, 16'd0);
        tick();
        chk("en_after_load", {15'd0, count_en}, 16'd1);
        chk("load_drop", {15'd0, load}, 16'd0);
        chk("load_data_hold", load_data, 16'h1230);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        chk("done_state", 16'(state), 16'd5);
        chk("done_en", {14'd0, done, count_en}, 16'b10);
        tick();
        chk("done_held", {15'd0, done}, 16'd1);
        key(4'd7);
        chk("done_key_state", 16'(state), 16'd1);
        chk("done_key_entry", entry_digits, 16'h0007);
        chk("done_key_done", {15'd0, done}, 16'd0);
        pulse_clear();
        chk("clr_state", 16'(state), 16'd0);
        chk("clr_entry", entry_digits, 16'h0000);
        chk("clr_keeps_ld", load_data, 16'h1230);
    endtask

    task automatic test_illegal_start();
        key(4'd1); key(4'd7); key(4'd0);
        pulse_start();
        chk("ill_err", {15'd0, err}, 16'd1);
        chk("ill_state", 16'(state), 16'd1);
        chk("ill_entry", entry_digits, 16'h0170);
        tick();
        chk("ill_err_pulse", {15'd0, err}, 16'd0);
        pulse_clear();
        chk("ill_clr_state", 16'(state), 16'd0);
        chk("ill_clr_entry", entry_digits, 16'h0000);
        key(4'd0); key(4'd0);
        pulse_start();
        chk("zero_err", {15'd0, err}, 16'd1);
        chk("zero_state", 16'(state), 16'd1);
        pulse_clear();
        key(4'd6); key(4'd0);
        pulse_start();
        chk("sec60_err", {15'd0, err}, 16'd1);
        pulse_clear();
        key(4'd5); key(4'd9);
        sb.push_back(16'h0059);
        pulse_start();
        chk("sec59_state", 16'(state), 16'd2);
        chk("sec59_err", {15'd0, err}, 16'd0);
        tick();
        pulse_clear();
    endtask

    task automatic test_pause();
        key(4'd0); key(4'd4); key(4'd5);
        chk("p_entry", entry_digits, 16'h0045);
        sb.push_back(16'h0045);
        pulse_start();
        tick();
        chk("p_run", 16'(state), 16'd3);
        pause = 1'b1;
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        chk("p_paused", 16'(state), 16'd4);
        chk("p_en_off", {15'd0, count_en}, 16'd0);
        pulse_start();
        chk("p_start_ignored", 16'(state), 16'd4);
        pause = 1'b0;
        tick();
        chk("p_still_paused", 16'(state), 16'd4);
        pulse_start();
        chk("p_resume", 16'(state), 16'd3);
        chk("p_en_on", {15'd0, count_en}, 16'd1);
        pulse_clear();
        chk("p_clr_en", {15'd0, count_en}, 16'd0);
    endtask

    task automatic test_overflow_keys();
        key(4'd9); key(4'd9); key(4'd5); key(4'd9);
        key(4'd8);
        key(4'd12);
        chk("ov_entry", entry_digits, 16'h9959);
        sb.push_back(16'h9959);
        pulse_start();
        tick();
        chk("ov_run", 16'(state), 16'd3);
        pulse_clear();
        key(4'd12);
        chk("bad_key_idle", 16'(state), 16'd0);
        key(4'd3);
        key_valid = 1'b1;
        key_digit = 4'd4;
        sb.push_back(16'h0003);
        pulse_start();
        key_valid = 1'b0;
        chk("key_start_drop", load_data, 16'h0003);
        tick();
        pulse_clear();
    endtask

    task automatic test_async_reset();
        key(4'd1);
        sb.push_back(16'h0001);
        pulse_start();
        tick();
        chk("ar_run_en", {15'd0, count_en}, 16'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_outs", {13'd0, count_en, load, done}, 16'd0);
        chk("ar_state", 16'(state), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_idle_start();
`ifdef QUICK_START_EN
        sb.push_back(16'h0030);
        pulse_start();
        chk("qs_load", 16'(state), 16'd2);
        tick();
        chk("qs_run", 16'(state), 16'd3);
        chk("qs_ld", load_data, 16'h0030);
        pulse_clear();
`else
        pulse_start();
        chk("is_state", 16'(state), 16'd0);
        chk("is_no_err_load", {14'd0, err, load}, 16'd0);
        tick();
        chk("is_no_err_late", {14'd0, err, load}, 16'd0);
`endif
    endtask

    initial begin
        test_reset();
        test_load_run_done();
        test_illegal_start();
        test_pause();
        test_overflow_keys();
        test_async_reset();
        test_idle_start();
        tick();
        tick();
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
